line_k_buffer: RTL and testbench
================================

LINE_K_BUFFER -- requirements
Module: line_k_buffer

Interface
REQ-001 SHALL have parameter D, default 1, input channel count per pixel.
REQ-002 SHALL have parameter H, default 24, rows per frame.
REQ-003 SHALL have parameter W, default 24, pixels per row.
REQ-004 SHALL have parameter DATA_BITS, default 8, bits per channel sample.
REQ-005 SHALL have parameter KR, default 3, window height in rows; odd, 1 <= KR <= H.
REQ-006 SHALL define P = (KR-1)/2 when LINEBUF_PAD_EN is defined, else P = 0, and RW = (W+2*P)*D*DATA_BITS (output row width).
REQ-007 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have resetn, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have input_data, input, W*D*DATA_BITS, one image row.
REQ-010 SHALL have valid_i, input, 1, input_data valid.
REQ-011 SHALL have ready_o, output, 1, block accepts a row this cycle.
REQ-012 SHALL have output_rows, output, KR*RW, window rows; row 0 = oldest, at LSBs.
REQ-013 SHALL have valid_o, output, 1, output_rows holds a complete window.
REQ-014 SHALL have behind_conv_done, input, 1, one-cycle consumer acknowledge of the current window.
REQ-015 SHALL have frame_done, output, 1, one-cycle pulse after the last window of a frame is acknowledged.

Function
REQ-016 A row SHALL be accepted only on a cycle with valid_i=1 and ready_o=1; valid_i with ready_o=0 SHALL be ignored.
REQ-017 On acceptance, window rows SHALL shift (row k <= row k+1) and the new row SHALL load into row KR-1, with P zero pixels on each side.
REQ-018 FSM states SHALL be IDLE, LOAD, EMIT, FLUSH; encoding taken from the shared package.
REQ-019 IDLE: ready_o=1, all window rows zero; first accepted row -> LOAD, row counter = 1.
REQ-020 LOAD: ready_o=1; when accepted-row count reaches P+1 + (outputs issued) within the first window, or KR when P=0, -> EMIT in the next cycle.
REQ-021 EMIT: valid_o=1, ready_o=0, output_rows stable; behind_conv_done=1 -> next state in the next cycle; behind_conv_done in any other state SHALL be ignored.
REQ-022 From EMIT after ack: if rows received < H -> LOAD; if rows received = H and windows issued < H-2*P+2*P... i.e. fewer than (P>0 ? H : H-KR+1) -> FLUSH; else frame_done pulse and -> IDLE.
REQ-023 FLUSH: shift in an all-zero row (bottom padding), ready_o=0, -> EMIT in one cycle.
REQ-024 Windows per frame SHALL be H with padding, H-KR+1 without.
REQ-025 Latency from accepting the row completing a window to valid_o=1 SHALL be exactly 1 cycle.
REQ-026 KR=1 SHALL emit every row directly (pass-through with handshake).

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, ready_o=0 during reset, valid_o=0, frame_done=0, output_rows=0, counters=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; first row after release starts a new frame.

Configuration
REQ-029 Macro LINEBUF_PAD_EN defined: zero padding P on all four borders, H windows per frame, FLUSH used.
REQ-030 LINEBUF_PAD_EN undefined: P=0, no padding, H-KR+1 windows, FLUSH never entered.

Structure
REQ-031 Shared package cnn_pkg SHALL hold FSM state constants and the padded-width function RW.
REQ-032 One sub-module line_row_reg (one RW-wide row register with load/clear) SHALL be instantiated KR times.

Verification (D=1, W=4, H=4, KR=3, DATA_BITS=8, rows r0..r3 with pixel values 1..16)
REQ-033 PAD_EN, rows fed back-to-back, ack 2 cycles after each valid_o -> 4 windows: {0,r0,r1},{r0,r1,r2},{r1,r2,r3},{r2,r3,0}, each row 6 px with zero ends; frame_done after 4th ack.
REQ-034 No PAD_EN, same stimulus -> 2 windows {r0,r1,r2},{r1,r2,r3}; FLUSH never entered; frame_done after 2nd ack.
REQ-035 valid_i held high throughout EMIT -> ready_o=0, no row consumed, window unchanged until ack.
REQ-036 behind_conv_done pulsed in IDLE/LOAD -> no state change, no extra window.
REQ-037 resetn low after 2nd window, then new frame -> outputs 0 during reset; next frame's first window equals REQ-033's first.
REQ-038 Two frames back-to-back -> 8 windows, 2 frame_done pulses, second frame windows free of first-frame data.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: FSM state encodings and row-width helpers for the line buffer.
// Padding depth follows LINEBUF_PAD_EN so port widths can use it.
package cnn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    function automatic int pad_of(input int kr);
`ifdef LINEBUF_PAD_EN
        return (kr - 1) / 2;
`else
        return 0 * kr;
`endif
    endfunction

    function automatic int rw(input int w, input int d,
                              input int bits, input int p);
        return (w + 2 * p) * d * bits;
    endfunction

endpackage

// File: rtl/line_row_reg.sv
// line_row_reg: one padded window row with clear and load.
module line_row_reg
    import cnn_pkg::*;
#(
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          load,
    input  logic [RW-1:0] d,
    output logic [RW-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/line_k_buffer.sv
// line_k_buffer: KR-row sliding window over image rows with handshake.
// Define LINEBUF_PAD_EN for zero padding of P=(KR-1)/2 on all borders.
module line_k_buffer
    import cnn_pkg::*;
#(
    parameter int D         = 1,
    parameter int H         = 24,
    parameter int W         = 24,
    parameter int DATA_BITS = 8,
    parameter int KR        = 3
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic [W*D*DATA_BITS-1:0]                      input_data,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic [KR*rw(W, D, DATA_BITS, pad_of(KR))-1:0] output_rows,
    output logic                                          valid_o,
    input  logic                                          behind_conv_done,
    output logic                                          frame_done
);

    localparam int P    = pad_of(KR);
    localparam int RW   = rw(W, D, DATA_BITS, P);
    localparam int BASE = KR - P;
    localparam int WPF  = H - KR + 1 + 2 * P;
    localparam int CW   = $clog2(H + 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] rows_q, rows_d;
    logic [CW-1:0] wins_q, wins_d;
    logic          done_q, done_d;
    logic          clear;
    logic          accept;
    logic          shift;
    logic [RW-1:0] fill;
    logic [RW-1:0] win_q [KR];

    assign ready_o = resetn &
                     ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign valid_o    = (state_q == ST_EMIT);
    assign frame_done = done_q;
    assign accept     = valid_i & ready_o;
    assign shift      = accept | (state_q == ST_FLUSH);

    // Bottom padding shifts in an all-zero row; side padding is the shift.
    assign fill = (state_q == ST_FLUSH) ? '0
                : RW'(input_data) << (P * D * DATA_BITS);

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        wins_d  = wins_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE), (state_q == ST_LOAD): begin
                if (accept) begin
                    rows_d = rows_q + CW'(1);
                    if (int'(rows_q) + 1 >= BASE + int'(wins_q))
                        state_d = ST_EMIT;
                    else
                        state_d = ST_LOAD;
                end
            end
            (state_q == ST_EMIT): begin
                if (behind_conv_done) begin
                    wins_d = wins_q + CW'(1);
                    if (int'(rows_q) < H) begin
                        state_d = ST_LOAD;
                    end else if (int'(wins_q) + 1 < WPF) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        clear   = 1'b1;
                        rows_d  = '0;
                        wins_d  = '0;
                    end
                end
            end
            (state_q == ST_FLUSH): begin
                state_d = ST_EMIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            wins_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            wins_q  <= wins_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < KR; k++) begin : g_row
        logic [RW-1:0] d;
        if (k == KR - 1) begin : g_top
            assign d = fill;
        end else begin : g_mid
            assign d = win_q[k+1];
        end
        line_row_reg #(.RW(RW)) u_row (
            .clk    (clk),
            .resetn (resetn),
            .clear  (clear),
            .load   (shift),
            .d      (d),
            .q      (win_q[k])
        );
        assign output_rows[k*RW +: RW] = win_q[k];
    end

endmodule

// File: tb/tb_line_k_buffer.sv
// tb_line_k_buffer: directed bench, D=1 W=4 H=4 KR=3, pixels 1..16.
// Expectations follow LINEBUF_PAD_EN when it is defined.
module tb_line_k_buffer;

`ifdef LINEBUF_PAD_EN
    localparam int RW = 48;
    localparam int NW = 4;
`else
    localparam int RW = 32;
    localparam int NW = 2;
`endif
    localparam logic [31:0] R0 = 32'h04030201;
    localparam logic [31:0] R1 = 32'h08070605;
    localparam logic [31:0] R2 = 32'h0C0B0A09;
    localparam logic [31:0] R3 = 32'h100F0E0D;
    localparam logic [RW-1:0] ZR = '0;

    logic            clk;
    logic            resetn;
    logic [31:0]     input_data;
    logic            valid_i;
    logic            ready_o;
    logic [3*RW-1:0] output_rows;
    logic            valid_o;
    logic            behind_conv_done;
    logic            frame_done;

    int checks = 0;
    int errors = 0;
    int n_acks = 0;
    int n_done = 0;

    line_k_buffer #(
        .D(1), .H(4), .W(4), .DATA_BITS(8), .KR(3)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .input_data       (input_data),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .output_rows      (output_rows),
        .valid_o          (valid_o),
        .behind_conv_done (behind_conv_done),
        .frame_done       (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid_o && behind_conv_done) n_acks <= n_acks + 1;
        if (frame_done) n_done <= n_done + 1;
    end

    function automatic logic [RW-1:0] pr(input logic [31:0] r);
`ifdef LINEBUF_PAD_EN
        return {8'h00, r, 8'h00};
`else
        return r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] r);
        int k = 0;
        valid_i    = 1'b1;
        input_data = r;
        while (!ready_o && k < 20) begin
            tick();
            k++;
        end
        chk("send_ready", ready_o, 1'b1);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic win(input string tag, input logic [3*RW-1:0] exp);
        chk({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_rows"}, output_rows, exp);
    endtask

    task automatic hold(input logic [31:0] r, input logic [3*RW-1:0] exp);
        valid_i    = 1'b1;
        input_data = r;
        repeat (2) begin
            tick();
            chk("hold_ready", ready_o, 1'b0);
            chk("hold_valid", valid_o, 1'b1);
            chk("hold_rows", output_rows, exp);
        end
        valid_i = 1'b0;
    endtask

    task automatic ack(input logic exp_done);
        behind_conv_done = 1'b1;
        tick();
        behind_conv_done = 1'b0;
        chk("frame_done", frame_done, exp_done);
        if (exp_done) begin
            tick();
            chk("done_pulse", frame_done, 1'b0);
            chk("idle_rows", output_rows, '0);
            chk("idle_ready", ready_o, 1'b1);
        end
    endtask

    task automatic poke(input string tag);
        behind_conv_done = 1'b1;
        tick();
        behind_conv_done = 1'b0;
        tick();
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_ready"}, ready_o, 1'b1);
    endtask

    // stop=n returns while window n is on display, before its ack.
    task automatic run_frame(input int stop, input bit pokes);
        if (pokes) poke("poke_idle");
        send(R0);
        chk("r0_valid", valid_o, 1'b0);
        if (pokes) poke("poke_load");
`ifdef LINEBUF_PAD_EN
        send(R1);
        win("w0", {pr(R1), pr(R0), ZR});
        hold(R2, {pr(R1), pr(R0), ZR});
        ack(1'b0);
        send(R2);
        win("w1", {pr(R2), pr(R1), pr(R0)});
        if (stop == 2) return;
        ack(1'b0);
        send(R3);
        win("w2", {pr(R3), pr(R2), pr(R1)});
        ack(1'b0);
        tick();
        win("w3", {ZR, pr(R3), pr(R2)});
        ack(1'b1);
`else
        send(R1);
        chk("r1_valid", valid_o, 1'b0);
        send(R2);
        win("w0", {pr(R2), pr(R1), pr(R0)});
        hold(R3, {pr(R2), pr(R1), pr(R0)});
        ack(1'b0);
        send(R3);
        win("w1", {pr(R3), pr(R2), pr(R1)});
        if (stop == 2) return;
        ack(1'b1);
`endif
    endtask

    initial begin
        resetn           = 1'b0;
        valid_i          = 1'b0;
        behind_conv_done = 1'b0;
        input_data       = '0;
        #3;
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_rows", output_rows, '0);
        tick();
        resetn = 1'b1;
        tick();
        chk("idle_ready0", ready_o, 1'b1);

        run_frame(99, 1'b0);
        run_frame(99, 1'b1);

        run_frame(2, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ready", ready_o, 1'b0);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_done", frame_done, 1'b0);
        chk("mid_rst_rows", output_rows, '0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        run_frame(99, 1'b0);

        tick();
        chk("ack_count", n_acks, 3 * NW + 1);
        chk("done_count", n_done, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
